msg_frame_controller: RTL
=========================

Name: msg_frame_controller

Overview:
Serial message front-end controller. Hunts for a preamble of consecutive 1s on a single-bit serial line, then locks on the start bit. It shifts in a fixed-length payload, checks even parity, and presents the frame on a valid/ready interface to downstream logic. It sits between the raw serial input pin (already synchronised) and the message-processing datapath, and sequences all framing.

Parameters:
PREAMBLE_LEN, 4, number of consecutive 1s required before a start bit is accepted (>=2)
DATA_BITS, 8, payload width in bits, received LSB first (1..16)

Ports:
clock  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
enable  input  1  1 = hunt/receive allowed; 0 = return to IDLE (see Behaviour)
data_in  input  1  serial bit, sampled every rising clock edge
msg_ready  input  1  downstream accepts msg_data this cycle when msg_valid=1
msg_data  output  DATA_BITS  received payload, stable while msg_valid=1
msg_valid  output  1  frame available
parity_err  output  1  qualifies msg_data; 1 = received parity bit mismatched even parity
busy  output  1  1 in RECEIVE or PARITY states
frame_cnt  output  8  count of frames handed off (msg_valid & msg_ready), wraps 255->0

Behaviour:
- Reset: state=IDLE; msg_data=0, msg_valid=0, parity_err=0, busy=0, frame_cnt=0, internal ones counter=0, bit counter=0. Reset dominates every other input.
- All outputs are registered.
- States and transitions, evaluated each edge:
  - IDLE: if enable=1 -> HUNT with ones_cnt=0.
  - HUNT: data_in=1 -> ones_cnt saturating increment, max PREAMBLE_LEN. data_in=0 with ones_cnt<PREAMBLE_LEN -> ones_cnt=0, stay. data_in=0 with ones_cnt==PREAMBLE_LEN -> that bit is the start bit -> RECEIVE, bit_cnt=0. Runs longer than PREAMBLE_LEN ones stay armed.
  - RECEIVE: shift data_in into bit position bit_cnt (LSB first); after DATA_BITS samples -> PARITY.
  - PARITY: sample parity bit. parity_err <= (XOR of payload) XOR data_in. msg_data <= payload. msg_valid <= 1. -> DELIVER.
  - DELIVER: hold msg_data/msg_valid/parity_err stable. When msg_ready=1: msg_valid <= 0, frame_cnt++, -> HUNT (enable=1) or IDLE (enable=0), ones_cnt=0.
- Latency: msg_valid rises exactly one cycle after the edge that samples the parity bit. Total is PREAMBLE_LEN+1+DATA_BITS+1 edges from the first preamble bit, plus 1.
- The serial line is ignored in DELIVER. A preamble arriving during DELIVER is not detected; hunting restarts from ones_cnt=0.
- enable=0 in HUNT, RECEIVE or PARITY -> IDLE next edge. The partial frame is discarded and msg_valid stays 0. enable=0 in DELIVER has no effect until the handshake completes.
- msg_ready while msg_valid=0 is ignored.
- busy = (state==RECEIVE) | (state==PARITY), registered with the state.

Decomposition:
- Shared package msg_pkg holds: state enum (IDLE, HUNT, RECEIVE, PARITY, DELIVER) as a 3-bit logic enum, and the default constants PREAMBLE_LEN/DATA_BITS.
- One natural sub-module: preamble_hunter. It contains the saturating ones counter plus the armed flag, with inputs clock, reset, clear and data_in, and output armed (ones_cnt==PREAMBLE_LEN). The controller instantiates it and pulses clear on leaving HUNT.

Test Plan:
1. enable=1, stream 1111 0 then 1010_0101 (0xA5 LSB first), parity 0, msg_ready=1 -> msg_valid=1 one cycle after the parity edge. msg_data=0xA5, parity_err=0, frame_cnt=1.
2. Same frame with parity bit 1 -> msg_data=0xA5, parity_err=1, frame_cnt=1.
3. Stream 111 0 1111111 0, payload 0x3C, parity 0 -> the first 0 resets the hunt, the long run stays armed, frame received with msg_data=0x3C.
4. Valid frame with msg_ready=0 for 5 cycles while data_in toggles, then msg_ready=1 -> msg_data/msg_valid stable for all 5 cycles, handoff on cycle 6, frame_cnt increments once, then hunting restarts.
5. Drop enable to 0 after 3 payload bits -> IDLE next cycle, msg_valid never asserts. Re-enable and send a full 0x81 frame -> msg_data=0x81.
6. Assert reset in DELIVER, and separately mid-RECEIVE -> next edge all outputs 0, frame_cnt=0. Also run 256 handshakes and check frame_cnt wraps to 0.

Source files
------------

// File: rtl/msg_pkg.sv
// Shared types and default sizing for the serial message framing controller.
package msg_pkg;

    localparam int DEF_PREAMBLE_LEN = 4;
    localparam int DEF_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HUNT    = 3'd1,
        ST_RECEIVE = 3'd2,
        ST_PARITY  = 3'd3,
        ST_DELIVER = 3'd4
    } state_t;

endpackage

// File: rtl/preamble_hunter.sv
// Counts consecutive 1s on the serial line, saturating at PREAMBLE_LEN.
// armed stays high for longer runs until a 0 arrives or clear is asserted.
module preamble_hunter
    import msg_pkg::*;
#(
    parameter int PREAMBLE_LEN = DEF_PREAMBLE_LEN
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic data_in,
    output logic armed
);

    localparam int CW = $clog2(PREAMBLE_LEN + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(PREAMBLE_LEN);

    logic [CW-1:0] ones_cnt_q;
    logic [CW-1:0] ones_cnt_d;

    always_comb begin
        ones_cnt_d = ones_cnt_q;
        if (clear) begin
            ones_cnt_d = '0;
        end else if (data_in) begin
            if (ones_cnt_q != MAX_CNT) begin
                ones_cnt_d = ones_cnt_q + CW'(1);
            end
        end else begin
            ones_cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ones_cnt_q <= '0;
        end else begin
            ones_cnt_q <= ones_cnt_d;
        end
    end

    assign armed = (ones_cnt_q == MAX_CNT);

endmodule

// File: rtl/msg_frame_controller.sv
// Serial framing controller: preamble hunt, start-bit lock, LSB-first payload,
// even-parity check, and valid/ready handoff of the received frame.
module msg_frame_controller
    import msg_pkg::*;
#(
    parameter int PREAMBLE_LEN = DEF_PREAMBLE_LEN,
    parameter int DATA_BITS    = DEF_DATA_BITS
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 data_in,
    input  logic                 msg_ready,
    output logic [DATA_BITS-1:0] msg_data,
    output logic                 msg_valid,
    output logic                 parity_err,
    output logic                 busy,
    output logic [7:0]           frame_cnt,
    output state_t               state_dbg
);

    // Handshake: a frame transfers on any edge where msg_valid and msg_ready
    // are both 1; msg_data/parity_err hold steady until then, and msg_ready
    // is ignored while msg_valid is 0.

    localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

    state_t               state_q,      state_d;
    logic [CW-1:0]        bit_cnt_q,    bit_cnt_d;
    logic [DATA_BITS-1:0] payload_q,    payload_d;
    logic [DATA_BITS-1:0] msg_data_q,   msg_data_d;
    logic                 msg_valid_q,  msg_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 busy_q,       busy_d;
    logic [7:0]           frame_cnt_q,  frame_cnt_d;

    logic hunt_clear;
    logic armed;

    // Holding clear outside HUNT guarantees every hunt starts from zero,
    // so 1s seen while receiving or delivering never count as preamble.
    assign hunt_clear = (state_q != ST_HUNT);

    preamble_hunter #(
        .PREAMBLE_LEN(PREAMBLE_LEN)
    ) u_hunter (
        .clock  (clock),
        .reset  (reset),
        .clear  (hunt_clear),
        .data_in(data_in),
        .armed  (armed)
    );

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        payload_d    = payload_q;
        msg_data_d   = msg_data_q;
        msg_valid_d  = msg_valid_q;
        parity_err_d = parity_err_q;
        frame_cnt_d  = frame_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_HUNT;
                end
            end
            ST_HUNT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (!data_in && armed) begin
                    state_d   = ST_RECEIVE;
                    bit_cnt_d = '0;
                end
            end
            ST_RECEIVE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    payload_d[bit_cnt_q] = data_in;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    parity_err_d = (^payload_q) ^ data_in;
                    msg_data_d   = payload_q;
                    msg_valid_d  = 1'b1;
                    state_d      = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                if (msg_ready) begin
                    msg_valid_d = 1'b0;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    state_d     = enable ? ST_HUNT : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RECEIVE) || (state_d == ST_PARITY);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            payload_q    <= '0;
            msg_data_q   <= '0;
            msg_valid_q  <= 1'b0;
            parity_err_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            payload_q    <= payload_d;
            msg_data_q   <= msg_data_d;
            msg_valid_q  <= msg_valid_d;
            parity_err_q <= parity_err_d;
            busy_q       <= busy_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign msg_data   = msg_data_q;
    assign msg_valid  = msg_valid_q;
    assign parity_err = parity_err_q;
    assign busy       = busy_q;
    assign frame_cnt  = frame_cnt_q;
    assign state_dbg  = state_q;

endmodule
